store_queue_ctrl: RTL and testbench

- In-order store queue and scheduler between the LSU store path and the data-memory write port.
- Accepts store requests, lane-aligns them into byte-masked word writes, buffers up to DEPTH entries, and drains them over a req/ack memory handshake.
- Provides a load-hazard check against pending stores.
- Provides a fence/drain sequence for the pipeline.

---
 rtl/store_queue_ctrl_pkg.sv | 25 ++
 rtl/store_queue_ctrl_lane_gen.sv | 37 +++
 rtl/store_queue_ctrl.sv | 136 +++++++++++++
 tb/tb_store_queue_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_ctrl_pkg.sv
// Shared types for the store queue: access widths, queue entry layout, control states.
package pcl_store_pkg;

  localparam int unsigned SQ_MAX_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_BYTE = 2'd0,
    ST_HALF = 2'd1,
    ST_WORD = 2'd2,
    ST_RSVD = 2'd3
  } st_width_e;

  typedef struct packed {
    logic [SQ_MAX_ADDR_W-3:0] word_addr;
    logic [3:0]               mask;
    logic [31:0]              dat;
  } sq_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sq_state_e;

endpackage

// File: rtl/store_queue_ctrl_lane_gen.sv
// Turns a right-justified store into byte strobes and lane-replicated data, flagging misalignment.
module store_lane_gen
  import pcl_store_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  off,
  input  logic [31:0] dat,
  output logic        misalign,
  output logic [3:0]  mask,
  output logic [31:0] wdat
);

  // Decode width into strobes/replicated data; reserved width is always an error.
  always_comb begin
    misalign = 1'b0;
    mask     = '0;
    wdat     = '0;
    unique case (st_width_e'(width))
      ST_BYTE: begin
        mask = 4'b0001 << off;
        wdat = {4{dat[7:0]}};
      end
      ST_HALF: begin
        misalign = off[0];
        mask     = 4'b0011 << off;
        wdat     = {2{dat[15:0]}};
      end
      ST_WORD: begin
        misalign = (off != 2'd0);
        mask     = 4'b1111;
        wdat     = dat;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_queue_ctrl.sv
// In-order store queue: lane-aligns stores, buffers them and drains over a req/ack port.
module store_queue_ctrl
  import pcl_store_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_vld,
  output logic              st_rdy,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_width,
  input  logic [31:0]       st_dat,
  output logic              st_err,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wr_mask,
  output logic [31:0]       mem_wr_dat,
  input  logic [ADDR_W-1:0] ld_chk_addr,
  output logic              ld_hazard,
  input  logic              fence_req,
  output logic              fence_done,
  output logic              idle
);

  localparam int unsigned    PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(DEPTH);

  // Word addresses are kept at package width so the entry struct is parameter-independent.
  function automatic logic [SQ_MAX_ADDR_W-3:0] word_of(input logic [ADDR_W-1:0] a);
    logic [SQ_MAX_ADDR_W-3:0] w;
    w = '0;
    w[ADDR_W-3:0] = a[ADDR_W-1:2];
    return w;
  endfunction

  sq_state_e       state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] valid;
  sq_entry_t        entries [DEPTH];
  sq_entry_t        new_entry;
  sq_entry_t        head;

  logic        misalign;
  logic [3:0]  lane_mask;
  logic [31:0] lane_dat;
  logic        st_hs, push, pop;
  logic [SQ_MAX_ADDR_W-3:0] chk_word;

  store_lane_gen u_lane (
    .width    (st_width),
    .off      (st_addr[1:0]),
    .dat      (st_dat),
    .misalign (misalign),
    .mask     (lane_mask),
    .wdat     (lane_dat)
  );

  assign st_rdy    = (count != FULL) && (state == RUN);
  assign st_hs     = st_vld && st_rdy;
  assign push      = st_hs && !misalign;
  assign mem_req   = (count != '0);
  assign pop       = mem_req && mem_ack;
  assign idle      = (count == '0) && (state == RUN);
  assign chk_word  = word_of(ld_chk_addr);

  assign new_entry = '{word_addr: word_of(st_addr), mask: lane_mask, dat: lane_dat};
  assign head        = entries[rd_ptr];
  assign mem_addr    = {head.word_addr[ADDR_W-3:0], 2'b00};
  assign mem_wr_mask = head.mask;
  assign mem_wr_dat  = head.dat;

  // Queue storage: payload needs no reset, validity lives in the valid vector.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= new_entry;
  end

  // Pointers, occupancy, per-entry valid bits and the misaligned-store pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= st_hs && misalign;
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Load hazard: any valid entry (including one popping this cycle) on the same word.
  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].word_addr == chk_word)) ld_hazard = 1'b1;
    end
  end

  // Fence state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Fence sequencing: block stores while draining, pulse done once empty.
  always_comb begin
    state_nxt  = state;
    fence_done = 1'b0;
    unique case (state)
      RUN:   if (fence_req) state_nxt = DRAIN;
      DRAIN: if (count == '0) state_nxt = DONE;
      DONE: begin
        fence_done = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Self-checking bench: queue-based reference model, directed scenarios, randomized traffic.
module tb_store_queue_ctrl;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              st_vld;
  logic              st_rdy;
  logic [ADDR_W-1:0] st_addr;
  logic [1:0]        st_width;
  logic [31:0]       st_dat;
  logic              st_err;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wr_mask;
  logic [31:0]       mem_wr_dat;
  logic [ADDR_W-1:0] ld_chk_addr;
  logic              ld_hazard;
  logic              fence_req;
  logic              fence_done;
  logic              idle;

  store_queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_vld      (st_vld),
    .st_rdy      (st_rdy),
    .st_addr     (st_addr),
    .st_width    (st_width),
    .st_dat      (st_dat),
    .st_err      (st_err),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_wr_mask (mem_wr_mask),
    .mem_wr_dat  (mem_wr_dat),
    .ld_chk_addr (ld_chk_addr),
    .ld_hazard   (ld_hazard),
    .fence_req   (fence_req),
    .fence_done  (fence_done),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending writes plus fence bookkeeping.
  typedef struct {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] dat;
  } ment_t;

  ment_t mq[$];
  bit    m_drain = 0;
  bit    m_done  = 0;
  bit    m_err   = 0;
  bit    model_ok = 0;

  function automatic bit bad_store(input logic [1:0] w, input logic [1:0] off);
    int unsigned n;
    n = 1 << w;
    return (w == 2'd3) || ((int'(off) % n) != 0);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] w, input logic [1:0] off);
    int unsigned n;
    n = 1 << w;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] lane_dat(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    int unsigned n;
    n = 1 << w;
    for (int unsigned b = 0; b < 4; b++) r[b*8 +: 8] = d[(b % n)*8 +: 8];
    return r;
  endfunction

  int unsigned p_sz;
  bit          p_rdy, p_hs, p_bad;
  ment_t       p_ent;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drain  = 0;
      m_done   = 0;
      m_err    = 0;
      model_ok = 1;
    end else if (model_ok) begin
      p_sz  = mq.size();
      p_rdy = (p_sz != DEPTH) && !m_drain && !m_done;
      p_hs  = st_vld && p_rdy;
      p_bad = bad_store(st_width, st_addr[1:0]);
      if (m_done) m_done = 0;
      else if (m_drain) begin
        if (p_sz == 0) begin
          m_drain = 0;
          m_done  = 1;
        end
      end else if (fence_req) m_drain = 1;
      if (p_sz != 0 && mem_ack) void'(mq.pop_front());
      if (p_hs && !p_bad) begin
        p_ent.waddr = st_addr[31:2];
        p_ent.mask  = lane_mask(st_width, st_addr[1:0]);
        p_ent.dat   = lane_dat(st_width, st_dat);
        mq.push_back(p_ent);
      end
      m_err = p_hs && p_bad;
    end
  end

  int unsigned c_sz;
  bit          c_hz;

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      c_sz = mq.size();
      chk("st_rdy", st_rdy, (c_sz != DEPTH) && !m_drain && !m_done);
      chk("mem_req", mem_req, c_sz != 0);
      chk("st_err", st_err, m_err);
      chk("fence_done", fence_done, m_done);
      chk("idle", idle, (c_sz == 0) && !m_drain && !m_done);
      c_hz = 0;
      foreach (mq[k]) if (mq[k].waddr == ld_chk_addr[31:2]) c_hz = 1;
      chk("ld_hazard", ld_hazard, c_hz);
      if (c_sz != 0) begin
        chk("mem_addr", mem_addr, {mq[0].waddr, 2'b00});
        chk("mem_wr_mask", mem_wr_mask, mq[0].mask);
        chk("mem_wr_dat", mem_wr_dat, mq[0].dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    st_vld    = 1'b0;
    mem_ack   = 1'b0;
    fence_req = 1'b0;
  endtask

  task automatic put(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    st_vld   = 1'b1;
    st_addr  = a;
    st_width = w;
    st_dat   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  bit seen;

  initial begin
    rst = 1'b1;
    quiet();
    st_addr = '0; st_width = '0; st_dat = '0; ld_chk_addr = 32'hFFFF_FFF0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_st_rdy", st_rdy, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_st_err", st_err, 1'b0);
    chk("rst_fence_done", fence_done, 1'b0);

    // Byte store with ack held high.
    put(32'h1003, 2'd0, 32'h0000_00AB);
    mem_ack = 1'b1;
    tick();
    st_vld = 1'b0;
    chk("byte_req", mem_req, 1'b1);
    chk("byte_addr", mem_addr, 32'h1000);
    chk("byte_mask", mem_wr_mask, 4'b1000);
    chk("byte_dat", mem_wr_dat, 32'hABAB_ABAB);
    tick();
    chk("byte_empty", mem_req, 1'b0);
    chk("byte_idle", idle, 1'b1);

    // Fill with no ack, then drain in order.
    mem_ack = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      put(i * 4, 2'd2, $urandom);
      tick();
    end
    st_vld = 1'b0;
    chk("full_rdy", st_rdy, 1'b0);
    mem_ack = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("fifo_req", mem_req, 1'b1);
      chk("fifo_addr", mem_addr, i * 4);
      tick();
      if (i == 0) chk("rdy_after_pop", st_rdy, 1'b1);
    end
    mem_ack = 1'b0;
    chk("fifo_empty", mem_req, 1'b0);

    // Misaligned half and reserved width are consumed but never queued.
    put(32'h2001, 2'd1, 32'h1234);
    tick();
    st_vld = 1'b0;
    chk("half_err", st_err, 1'b1);
    chk("half_noreq", mem_req, 1'b0);
    tick();
    chk("half_err_clr", st_err, 1'b0);
    put(32'h3000, 2'd3, 32'h5678);
    tick();
    st_vld = 1'b0;
    chk("rsvd_err", st_err, 1'b1);
    chk("rsvd_noreq", mem_req, 1'b0);
    tick();
    chk("rsvd_err_clr", st_err, 1'b0);

    // Load hazard against a pending half store at offset 2.
    put(32'h42, 2'd1, 32'h0000_BEEF);
    tick();
    st_vld = 1'b0;
    chk("haz_mask", mem_wr_mask, 4'b1100);
    chk("haz_dat", mem_wr_dat, 32'hBEEF_BEEF);
    ld_chk_addr = 32'h41; #1;
    chk("haz_same", ld_hazard, 1'b1);
    ld_chk_addr = 32'h44; #1;
    chk("haz_other", ld_hazard, 1'b0);
    ld_chk_addr = 32'h41; mem_ack = 1'b1; #1;
    chk("haz_popping", ld_hazard, 1'b1);
    tick();
    mem_ack = 1'b0;
    chk("haz_gone", ld_hazard, 1'b0);

    // Fence with three pending entries.
    for (int unsigned i = 0; i < 3; i++) begin
      put(32'h100 + i * 4, 2'd2, $urandom);
      tick();
    end
    st_vld = 1'b0;
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    chk("drain_rdy", st_rdy, 1'b0);
    chk("drain_idle", idle, 1'b0);
    mem_ack = 1'b1;
    seen = 0;
    for (int unsigned k = 0; k < 20 && !seen; k++) begin
      tick();
      if (fence_done) seen = 1;
    end
    chk("fence_done_seen", seen, 1'b1);
    mem_ack = 1'b0;
    tick();
    chk("fence_done_clr", fence_done, 1'b0);
    chk("post_fence_idle", idle, 1'b1);

    // Reset with entries pending.
    put(32'h200, 2'd2, 32'h1111_1111); tick();
    put(32'h204, 2'd2, 32'h2222_2222); tick();
    st_vld = 1'b0;
    ld_chk_addr = 32'h200;
    chk("pre_rst_req", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_rdy", st_rdy, 1'b1);
    chk("mid_rst_haz", ld_hazard, 1'b0);

    // Randomized traffic over a small address window so hazards recur.
    for (int unsigned n = 0; n < 2000; n++) begin
      st_vld      = ($urandom_range(0, 9) < 6);
      st_addr     = $urandom_range(0, 63);
      st_width    = 2'($urandom_range(0, 3));
      st_dat      = $urandom;
      mem_ack     = $urandom_range(0, 1) == 1;
      fence_req   = ($urandom_range(0, 19) == 0);
      ld_chk_addr = $urandom_range(0, 63);
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    quiet();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
